// File: rtl/phys_tag_free_list.sv
// rtl/phys_tag_free_list.sv - circular FIFO of free physical register tags for rename
module phys_tag_free_list #(
    parameter int NUM_TAGS = 32,
    parameter int TAG_W    = 5,
    parameter int RESV     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             free_valid,
    input  logic [TAG_W-1:0] free_tag,
    output logic [TAG_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam int               DEPTH    = NUM_TAGS - RESV;
    localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(DEPTH - 1);
    localparam logic [TAG_W:0]   DEPTH_C  = (TAG_W + 1)'(DEPTH);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [TAG_W-1:0] mem_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;
    logic             err_q, err_d;

    logic do_pop;
    logic do_push;
    logic free_legal;

    // DEPTH is not a power of two, so pointers wrap explicitly at the last slot.
    function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign empty       = (count_q == '0);
    assign full        = (count_q == DEPTH_C);
    assign alloc_valid = !empty;
    assign alloc_tag   = mem_q[head_q];
    assign count       = count_q;
    assign err         = err_q;

    // A full FIFO rejects a free even when a pop happens in the same cycle (no bypass).
    assign free_legal = (int'(free_tag) >= RESV) && (int'(free_tag) < NUM_TAGS) && !full;
    assign do_pop     = alloc_req && alloc_valid;
    assign do_push    = free_valid && free_legal;

    // Next-state: flush reloads the reset image; otherwise apply pop and push.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = TAG_W'(i + RESV);
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = DEPTH_C;
            err_d   = 1'b0;
        end else begin
            if (do_pop) begin
                head_d = ptr_inc(head_q);
            end
            if (do_push) begin
                mem_d[tail_q] = free_tag;
                tail_d        = ptr_inc(tail_q);
            end
            if (free_valid && !free_legal) begin
                err_d = 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; async reset loads tags RESV..NUM_TAGS-1 in order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= TAG_W'(i + RESV);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= DEPTH_C;
            err_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule
